// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with valid/ready handshake and shift-add multiply
// One operation in flight; result and flags held in DONE until the consumer takes them.
module seq_alu #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   res_q;
  logic               carry_q;
  logic               ovf_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [2*WIDTH-1:0] acc_next;
  logic               start_mul;
  logic               mul_last;

  // Single-cycle datapath works on the live inputs; its result is captured at accept.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (signal)
      3'b000: alu_res = a & b;
      3'b001: alu_res = a | b;
      3'b100: alu_res = a ^ b;
      3'b101: alu_res = ~(a | b);
      3'b010: begin
        sum     = {1'b0, a} + {1'b0, b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      3'b110: begin
        sum     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      3'b111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: ;
    endcase
  end

  assign start_mul = (signal == 3'b011) && (MUL_EN != 0);
  assign mul_last  = (cnt_q == CW'(WIDTH - 1));
  assign acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = start_mul ? MUL : DONE;
      MUL:     if (mul_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      res_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            res_q    <= alu_res;
            carry_q  <= alu_c;
            ovf_q    <= alu_v;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= '0;
          end
        end
        MUL: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          // Final iteration latches the product so DONE presents it directly.
          if (mul_last) begin
            res_q   <= acc_next[WIDTH-1:0];
            carry_q <= |acc_next[2*WIDTH-1:WIDTH];
            ovf_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = out_valid ? res_q : '0;
  assign zero      = out_valid && (res_q == '0);
  assign carry     = out_valid && carry_q;
  assign overflow  = out_valid && ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu with directed vectors
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] signal;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       zero;
  logic       carry;
  logic       overflow;

  typedef struct {
    logic [7:0] o;
    logic       z;
    logic       c;
    logic       v;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   busy = 1'b0;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  seq_alu #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signal(signal), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
    end else if (out_valid) begin
      if (!busy) begin
        busy = 1'b1;
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
          cur.o = out; cur.z = zero; cur.c = carry; cur.v = overflow; cur.cyc = cycle;
        end else begin
          cur = q.pop_front();
          chk("latency_cycle", cycle, cur.cyc);
        end
      end
      chk("out", out, cur.o);
      chk("zero", zero, cur.z);
      chk("carry", carry, cur.c);
      chk("overflow", overflow, cur.v);
      chk("in_ready_while_done", in_ready, 0);
      if (out_ready) busy = 1'b0;
    end else begin
      chk("idle_outputs_zero", {out, zero, carry, overflow}, 0);
    end
  end

  task automatic do_op(input logic [2:0] s, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [7:0] eo, input bit ez, input bit ec, input bit ev,
                       input int lat, input int hold);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_at_issue", in_ready, 1);
    q.push_back('{eo, ez, ec, ev, cycle + lat});
    in_valid = 1'b1; a = ia; b = ib; signal = s;
    @(posedge clk); #1;
    // Scramble inputs after the accept; the captured operation must be unaffected.
    in_valid = 1'b0; a = ~ia; b = ib + 8'h5A; signal = ~s;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("out_valid_seen", out_valid, 1);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_take", in_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_outputs"}, {out, zero, carry, overflow}, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; signal = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    do_op(3'b010, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 0);
    do_op(3'b110, 8'h02, 8'h05, 8'hFD, 0, 0, 0, 1, 0);
    do_op(3'b110, 8'h05, 8'h05, 8'h00, 1, 1, 0, 1, 0);
    do_op(3'b111, 8'hFE, 8'h01, 8'h01, 0, 0, 0, 1, 0);
    do_op(3'b111, 8'h01, 8'hFE, 8'h00, 1, 0, 0, 1, 0);
    do_op(3'b011, 8'h0F, 8'h11, 8'hFF, 0, 0, 0, 9, 0);
    do_op(3'b011, 8'h10, 8'h10, 8'h00, 1, 1, 0, 9, 0);
    do_op(3'b011, 8'hFF, 8'hFF, 8'h01, 0, 1, 0, 9, 0);
    do_op(3'b010, 8'h0A, 8'h05, 8'h0F, 0, 0, 0, 1, 3);
    do_op(3'b000, 8'h3C, 8'h0F, 8'h0C, 0, 0, 0, 1, 0);
    do_op(3'b001, 8'h50, 8'h0A, 8'h5A, 0, 0, 0, 1, 0);
    do_op(3'b100, 8'hFF, 8'h0F, 8'hF0, 0, 0, 0, 1, 0);
    do_op(3'b101, 8'hF0, 8'h0F, 8'h00, 1, 0, 0, 1, 0);
    do_op(3'b010, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 1, 1);
    do_op(3'b110, 8'h80, 8'h01, 8'h7F, 0, 1, 1, 1, 0);

    // Abort a multiply four cycles in; nothing may surface afterwards.
    chk("in_ready_before_abort", in_ready, 1);
    in_valid = 1'b1; a = 8'h0F; b = 8'h11; signal = 3'b011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("in_ready_mid_mul", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    repeat (2) begin @(posedge clk); #1; end
    chk_reset_outputs("held_reset");
    rst_n = 1'b1;
    chk("in_ready_after_release", in_ready, 1);
    repeat (12) begin @(posedge clk); #1; end
    do_op(3'b000, 8'h3C, 8'h0F, 8'h0C, 0, 0, 0, 1, 0);

    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter MUL_EN, default 1, meaning the multi-cycle multiply is implemented (0 = op 011 returns zero in one cycle).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand/opcode presented is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 The block SHALL have ports a and b, inputs, WIDTH bits each: operands.
REQ-008 The block SHALL have port signal, input, 3 bits: opcode.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result and flags are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-011 The block SHALL have port out, output, WIDTH bits: result.
REQ-012 The block SHALL have ports zero, carry and overflow, outputs, 1 bit each: result flags.

Function
REQ-013 Opcode decode SHALL be: 000 AND, 001 OR, 010 ADD, 110 SUB (a-b), 111 SLT (signed), 100 XOR, 101 NOR, 011 MUL (low WIDTH bits of unsigned a*b).
REQ-014 The FSM states SHALL be IDLE, MUL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 An accept SHALL occur when in_valid=1 and in_ready=1; a, b and signal SHALL be captured at that edge, and input changes afterwards SHALL be ignored.
REQ-016 Non-MUL ops SHALL go IDLE->DONE; out_valid SHALL be 1 in the cycle after the accept (1-cycle latency).
REQ-017 MUL with MUL_EN=1 SHALL go IDLE->MUL, run WIDTH shift-add iterations (one per cycle), then go to DONE; out_valid SHALL rise exactly WIDTH+1 cycles after the accept.
REQ-018 MUL with MUL_EN=0 SHALL behave as a 1-cycle op with out=0 and all flags 0.
REQ-019 In DONE, out_valid SHALL be 1, and out and the flags SHALL be held stable until out_ready=1; on that edge the FSM SHALL go to IDLE.
REQ-020 Back-to-back: the earliest next accept SHALL be the cycle after the DONE->IDLE transition (maximum throughput of one op per 2 cycles).
REQ-021 zero SHALL be 1 iff out==0, for every opcode.
REQ-022 For ADD, carry SHALL be the carry-out of a+b, and overflow SHALL be signed overflow (operands of the same sign, result of the opposite sign).
REQ-023 For SUB, the result SHALL be computed as a+~b+1; carry SHALL be that carry-out (1 iff a>=b unsigned); overflow SHALL be signed overflow.
REQ-024 For SLT, out SHALL be 1 if a<b (two's complement) and 0 otherwise, zero-extended to WIDTH; carry and overflow SHALL be 0.
REQ-025 For MUL, carry SHALL be 1 iff the upper WIDTH bits of the full 2*WIDTH product are non-zero; overflow SHALL be 0.
REQ-026 For AND, OR, XOR and NOR, carry and overflow SHALL be 0.
REQ-027 out, zero, carry and overflow SHALL be 0 whenever out_valid=0.

Reset
REQ-028 When rst_n=0, the block SHALL asynchronously enter IDLE, with in_ready=1, out_valid=0, out=0 and zero=carry=overflow=0.
REQ-029 Reset asserted mid-MUL or in DONE SHALL abandon the operation; no out_valid pulse SHALL follow the release of reset.
REQ-030 After rst_n deasserts, the first accept SHALL be possible at the first rising edge.

Verification (WIDTH=8)
REQ-031 ADD a=0x7F, b=0x01 -> one cycle after accept: out=0x80, overflow=1, carry=0, zero=0.
REQ-032 SUB a=0x02, b=0x05 -> out=0xFD, carry=0, overflow=0; SUB a=0x05, b=0x05 -> out=0x00, zero=1, carry=1.
REQ-033 SLT a=0xFE, b=0x01 -> out=0x01; SLT a=0x01, b=0xFE -> out=0x00, zero=1.
REQ-034 MUL a=0x0F, b=0x11 -> out_valid 9 cycles after accept, out=0xFF, carry=0; MUL a=0x10, b=0x10 -> out=0x00, zero=1, carry=1.
REQ-035 ADD a=0x0A, b=0x05 with out_ready held 0 for 3 cycles -> out=0x0F held, out_valid=1 and in_ready=0 throughout; in_ready=1 on the cycle after out_ready=1.
REQ-036 rst_n pulsed low 4 cycles into a MUL -> immediate IDLE with all outputs 0 and no out_valid afterwards; a following AND a=0x3C, b=0x0F -> out=0x0C.
